// File: rtl/pipe_select_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined radix-4 select tree.
package pipe_select_pkg;

    localparam int PIPE_SELECT_MAX_SEL = 256;

    // Number of radix-4 levels needed to resolve n inputs (a trailing odd bit gets a 2:1 level).
    function automatic int clog4(input int n);
        return ($clog2(n) + 1) / 2;
    endfunction

    function automatic int radix_bits(input int in_cnt);
        return (in_cnt >= 4) ? 2 : 1;
    endfunction

    // Word count at the input of tree level k; level NUM_STAGE is the single output word.
    function automatic int stage_words(input int num_log, input int k);
        int rem;
        rem = num_log - 2 * k;
        if (rem < 0) rem = 0;
        return 1 << rem;
    endfunction

    function automatic int stage_offset(input int num_log, input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) off += stage_words(num_log, i);
        return off;
    endfunction

endpackage

// File: rtl/pipe_select_stage.sv
// One tree level: radix-4 (or 2:1 for a lone sel bit) muxes followed by the level's register slice.
module pipe_select_stage
    import pipe_select_pkg::*;
#(
    parameter int IN_CNT    = 4,
    parameter int NUM_WIDTH = 64,
    parameter int SEL_W     = 4,
    parameter int SIDE_W    = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  en,
    input  logic                                                  in_valid,
    input  logic [IN_CNT*NUM_WIDTH-1:0]                           in_data,
    input  logic [SEL_W-1:0]                                      in_sel,
    input  logic [SIDE_W-1:0]                                     in_side,
    output logic                                                  out_valid,
    output logic [(IN_CNT >> radix_bits(IN_CNT))*NUM_WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]                                      out_sel,
    output logic [SIDE_W-1:0]                                     out_side
);

    localparam int RBITS   = radix_bits(IN_CNT);
    localparam int RADIX   = 1 << RBITS;
    localparam int OUT_CNT = IN_CNT / RADIX;

    logic [RBITS-1:0]             digit;
    logic [OUT_CNT*NUM_WIDTH-1:0] mux;

    assign digit = in_sel[RBITS-1:0];

    // NOTE: mux is cleared before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        mux = '0;
        for (int j = 0; j < OUT_CNT; j++) begin
            for (int r = 0; r < RADIX; r++) begin
                if (digit == RBITS'(r))
                    mux[j*NUM_WIDTH +: NUM_WIDTH] = in_data[(j*RADIX + r)*NUM_WIDTH +: NUM_WIDTH];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all levels shift together on one edge.
    // NOTE: payload registers are reset as well, since the last level drives data_out/tag_out directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_side  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            // Bubbles only clear the valid bit; payload keeps its old value to save toggles.
            if (in_valid) begin
                out_data <= mux;
                out_sel  <= in_sel >> RBITS;
                out_side <= in_side;
            end
        end
    end

endmodule

// File: rtl/pipe_select.sv
// Pipelined NUM_SEL:1 word select with valid/ready flow control and a tag sideband.
// Optional macro PIPE_SELECT_RANGE_CHECK_EN adds the sel_err port flagging sel >= NUM_SEL.
module pipe_select
    import pipe_select_pkg::*;
#(
    parameter int NUM_SEL   = 16,
    parameter int NUM_LOG   = 4,
    parameter int NUM_WIDTH = 64,
    parameter int NUM_TAG   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_WIDTH*NUM_SEL-1:0] data_in,
    input  logic [NUM_LOG-1:0]           sel,
    input  logic [NUM_TAG-1:0]           tag_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_WIDTH-1:0]         data_out,
    output logic [NUM_TAG-1:0]           tag_out
`ifdef PIPE_SELECT_RANGE_CHECK_EN
    ,
    output logic                         sel_err
`endif
);

    localparam int NUM_STAGE = clog4(NUM_SEL);
    localparam int NUM_PAD   = 1 << NUM_LOG;
    localparam int BUS_WORDS = stage_offset(NUM_LOG, NUM_STAGE + 1);
    localparam int OUT_OFF   = stage_offset(NUM_LOG, NUM_STAGE);
`ifdef PIPE_SELECT_RANGE_CHECK_EN
    localparam int SIDE_W    = NUM_TAG + 1;
`else
    localparam int SIDE_W    = NUM_TAG;
`endif

    logic                         en;
    logic [NUM_PAD*NUM_WIDTH-1:0] data_pad;
    logic [SIDE_W-1:0]            side_in;

    // Every level's data vector lives in one flat bus, level k at word offset stage_offset(k).
    wire  [BUS_WORDS*NUM_WIDTH-1:0] data_bus;
    wire  [NUM_STAGE:0]             valid_bus;
    wire  [NUM_LOG-1:0]             sel_bus  [NUM_STAGE+1];
    wire  [SIDE_W-1:0]              side_bus [NUM_STAGE+1];
    wire  [NUM_LOG-1:0]             sel_unused;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    // Unused tree leaves are tied to zero, so an out-of-range select yields a zero word.
    always_comb begin
        data_pad = '0;
        data_pad[NUM_SEL*NUM_WIDTH-1:0] = data_in;
    end

`ifdef PIPE_SELECT_RANGE_CHECK_EN
    assign side_in = {int'(sel) >= NUM_SEL, tag_in};
`else
    assign side_in = tag_in;
`endif

    assign data_bus[NUM_PAD*NUM_WIDTH-1:0] = data_pad;
    assign valid_bus[0] = in_valid;
    assign sel_bus[0]   = sel;
    assign side_bus[0]  = side_in;

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        localparam int IN_CNT  = stage_words(NUM_LOG, k);
        localparam int IN_OFF  = stage_offset(NUM_LOG, k);
        localparam int NXT_CNT = stage_words(NUM_LOG, k + 1);
        localparam int NXT_OFF = stage_offset(NUM_LOG, k + 1);

        pipe_select_stage #(
            .IN_CNT    (IN_CNT),
            .NUM_WIDTH (NUM_WIDTH),
            .SEL_W     (NUM_LOG),
            .SIDE_W    (SIDE_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_valid  (valid_bus[k]),
            .in_data   (data_bus[IN_OFF*NUM_WIDTH +: IN_CNT*NUM_WIDTH]),
            .in_sel    (sel_bus[k]),
            .in_side   (side_bus[k]),
            .out_valid (valid_bus[k+1]),
            .out_data  (data_bus[NXT_OFF*NUM_WIDTH +: NXT_CNT*NUM_WIDTH]),
            .out_sel   (sel_bus[k+1]),
            .out_side  (side_bus[k+1])
        );
    end

    // All sel bits are consumed by the last level; what remains is always zero.
    assign sel_unused = sel_bus[NUM_STAGE];

    assign out_valid = valid_bus[NUM_STAGE];
    assign data_out  = data_bus[OUT_OFF*NUM_WIDTH +: NUM_WIDTH];
    assign tag_out   = side_bus[NUM_STAGE][NUM_TAG-1:0];
`ifdef PIPE_SELECT_RANGE_CHECK_EN
    assign sel_err   = side_bus[NUM_STAGE][NUM_TAG];
`endif

endmodule

// File: doc/pipe_select.md
PIPE_SELECT -- requirements
Module: pipe_select

Interface
REQ-001 SHALL have parameter NUM_SEL, default 16: number of input words (2..256).
REQ-002 SHALL have parameter NUM_LOG, default 4: select width, equal to clog2(NUM_SEL).
REQ-003 SHALL have parameter NUM_WIDTH, default 64: word width in bits.
REQ-004 SHALL have parameter NUM_TAG, default 8: sideband tag width carried alongside the data.
REQ-005 SHALL have ports in this order:
  - clk  in  1: single clock, all logic on the rising edge.
  - rst  in  1: synchronous, active-high reset.
  - in_valid  in  1: the input beat is valid.
  - in_ready  out  1: the block accepts the input beat.
  - data_in  in  NUM_WIDTH*NUM_SEL: word i is bits [NUM_WIDTH*i +: NUM_WIDTH].
  - sel  in  NUM_LOG: word index to select.
  - tag_in  in  NUM_TAG: sideband value, passed through unchanged.
  - out_valid  out  1: the output beat is valid.
  - out_ready  in  1: the downstream accepts the output beat.
  - data_out  out  NUM_WIDTH: the selected word.
  - tag_out  out  NUM_TAG: the tag that entered with this beat.
  - sel_err  out  1: the select was out of range (present only with the macro in REQ-018).

Function
REQ-006 SHALL implement the mux as a radix-4 tree with NUM_STAGE = ceil(NUM_LOG/2) register stages.
  - Stage k resolves sel bits [2k+1:2k].
  - A stage resolving only 1 bit uses a 2:1 mux.
REQ-007 SHALL accept a beat when in_valid && in_ready are both high on a rising clk edge.
REQ-008 SHALL present the accepted beat with out_valid=1 exactly NUM_STAGE cycles after acceptance when out_ready is held high (16 words: 2 cycles).
REQ-009 SHALL compute data_out as word[sel] of the data_in value captured at acceptance.
REQ-010 SHALL carry the remaining sel bits, tag_in and a valid bit through every stage alongside the data.
REQ-011 SHALL use one global advance enable, en = out_ready || !out_valid.
  - All stage registers load only when en is high.
  - in_ready = en, combinational, with no dependency on in_valid.
REQ-012 SHALL hold data_out, tag_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-013 SHALL NOT collapse internal bubbles.
  - An invalid stage still takes one advance to drain.
  - Throughput is one beat per cycle when out_ready=1.
REQ-014 SHALL accept a new input in the same cycle the output is consumed, with no cycle lost.
REQ-015 SHALL NOT update the data and tag registers of invalid stages.
  - Only valid bits toggle on those stages, for power.
  - Contents of invalid stages are don't-care.

Reset
REQ-016 SHALL clear every stage valid bit on rst; out_valid=0 in the cycle after rst is sampled high.
  - data_out, tag_out and sel_err reset to 0.
  - in_ready=1 after reset.
REQ-017 SHALL discard all in-flight beats when rst asserts mid-operation.
  - in_valid is ignored while rst=1.
  - No beat accepted before reset appears on the output afterwards.

Configuration
REQ-018 SHALL compile the sel_err port and its logic only when macro PIPE_SELECT_RANGE_CHECK_EN is defined.
  - Defined: sel >= NUM_SEL (possible only when NUM_SEL is not a power of 2) sets sel_err=1, aligned with that beat's out_valid.
  - Defined: data_out is 0 for that beat.
  - Undefined: no sel_err port; out-of-range data_out is unspecified.

Structure
REQ-019 SHALL place in shared package pipe_select_pkg:
  - function clog4 (stage count);
  - constant PIPE_SELECT_MAX_SEL = 256.
REQ-020 SHALL instantiate one sub-module, pipe_select_stage, per tree level.
  - Each instance is parametrised by its input-group count and NUM_WIDTH.
  - Each instance contains its register slice and the radix-4/2 muxes.

Verification
REQ-021 SHALL cover: NUM_SEL=16, word i = 64'h1111_1111_1111_1111*i, sel=5, tag=8'hA5, out_ready=1 -> data_out=64'h5555_5555_5555_5555, tag_out=8'hA5, 2 cycles after acceptance.
REQ-022 SHALL cover: back-to-back sel=0..15 with out_ready=1 -> 16 consecutive outputs, words 0..15 in order, no gaps.
REQ-023 SHALL cover: 3 beats issued, out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1; output held stable; all 3 beats delivered in order after release.
REQ-024 SHALL cover: rst pulsed 1 cycle with 2 beats in flight -> out_valid=0 the next cycle; neither beat ever appears.
REQ-025 SHALL cover: NUM_SEL=12, macro defined, sel=13 -> sel_err=1, data_out=0; the following beat with sel=11 -> sel_err=0, data_out=word 11.
REQ-026 SHALL cover: random in_valid/out_ready at 50% against a reference model over 10k beats -> zero mismatches, no beat lost or duplicated.
